// File: rtl/rgmii_tx_multispeed.sv
// Tri-speed RGMII transmit engine: accepts GMII bytes on a ready strobe and produces
// rise/fall bit pairs for external ODDR cells driving TXC, TX_CTL and TXD[3:0].
module rgmii_tx_multispeed #(
    parameter int DIV_100     = 5,
    parameter int DIV_10      = 50,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   gmii_tx_clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             speed_sel_i,
    input  logic                   gmii_tx_en_i,
    input  logic                   gmii_tx_er_i,
    input  logic [7:0]             gmii_txd_i,
    output logic                   gmii_tx_ready_o,
    output logic                   txc_rise_o,
    output logic                   txc_fall_o,
    output logic                   ctl_rise_o,
    output logic                   ctl_fall_o,
    output logic [3:0]             txd_rise_o,
    output logic [3:0]             txd_fall_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int CYC_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [1:0] {
        MODE_10   = 2'b00,
        MODE_100  = 2'b01,
        MODE_1000 = 2'b10
    } mode_e;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    function automatic mode_e decode_speed(input logic [1:0] sel);
        case (sel)
            2'b01:   return MODE_100;
            2'b00:   return MODE_10;
            default: return MODE_1000;
        endcase
    endfunction

    mode_e                  mode_q, mode_d;
    phase_e                 phase_q, phase_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic                   active_q, active_d;
    logic                   en_q, en_d;
    logic                   er_q, er_d;
    logic [7:0]             txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CYC_W-1:0]       n_last;
    logic                   ready;
    logic [CYC_W+1:0]       h_rise, h_fall, n_full;
    logic [3:0]             nibble;

    always_comb begin
        n_last = (mode_q == MODE_100) ? CYC_W'(DIV_100 - 1) : CYC_W'(DIV_10 - 1);
        // active_q holds off the first slot until one cycle after reset release
        ready  = active_q && ((mode_q == MODE_1000) || (phase_q == PH_HI && cyc_q == n_last));

        mode_d      = mode_q;
        phase_d     = phase_q;
        cyc_d       = cyc_q;
        active_d    = 1'b1;
        en_d        = en_q;
        er_d        = er_q;
        txd_d       = txd_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;

        if (active_q && mode_q != MODE_1000) begin
            if (cyc_q == n_last) begin
                cyc_d   = '0;
                phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end

        if (ready) begin
            en_d   = gmii_tx_en_i;
            er_d   = gmii_tx_er_i;
            txd_d  = gmii_tx_en_i ? gmii_txd_i : 8'h00;
            busy_d = gmii_tx_en_i;
            if (gmii_tx_en_i && !busy_q) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
            // Speed may only change in a clean idle slot so a frame is never split across modes
            if (!gmii_tx_en_i && !gmii_tx_er_i) begin
                mode_d = decode_speed(speed_sel_i);
            end
            cyc_d   = '0;
            phase_d = PH_LO;
        end
    end

    always_ff @(posedge gmii_tx_clk_i) begin
        if (rst_i) begin
            mode_q      <= decode_speed(speed_sel_i);
            phase_q     <= PH_LO;
            cyc_q       <= '0;
            active_q    <= 1'b0;
            en_q        <= 1'b0;
            er_q        <= 1'b0;
            txd_q       <= 8'h00;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            cyc_q       <= cyc_d;
            active_q    <= active_d;
            en_q        <= en_d;
            er_q        <= er_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // TXC goes high once the half-cycle index reaches N, centring the clock edge on the nibble
    always_comb begin
        h_rise = {1'b0, cyc_q, 1'b0};
        h_fall = h_rise + (CYC_W + 2)'(1);
        n_full = {2'b00, n_last} + (CYC_W + 2)'(1);
        nibble = (phase_q == PH_HI) ? txd_q[7:4] : txd_q[3:0];

        txc_rise_o = 1'b0;
        txc_fall_o = 1'b0;
        ctl_rise_o = 1'b0;
        ctl_fall_o = 1'b0;
        txd_rise_o = 4'h0;
        txd_fall_o = 4'h0;

        if (active_q) begin
            ctl_rise_o = en_q;
            ctl_fall_o = en_q ^ er_q;
            if (mode_q == MODE_1000) begin
                txc_rise_o = 1'b1;
                txd_rise_o = txd_q[3:0];
                txd_fall_o = txd_q[7:4];
            end else begin
                txc_rise_o = (h_rise >= n_full);
                txc_fall_o = (h_fall >= n_full);
                txd_rise_o = nibble;
                txd_fall_o = nibble;
            end
        end
    end

    assign gmii_tx_ready_o = ready;
    assign busy_o          = busy_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_rgmii_tx_multispeed.sv
// Directed bench for rgmii_tx_multispeed: 1000 passthrough table, then hand-written
// sequences for 100/10 serialisation, deferred speed change, reset and counter wrap.
module tb_rgmii_tx_multispeed;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] speedSel;
    logic       txEn, txEr;
    logic [7:0] txData;
    logic       ready, txcRise, txcFall, ctlRise, ctlFall, busy;
    logic [3:0] txdRise, txdFall;
    logic [3:0] frameCnt;

    int asserts  = 0;
    int failures = 0;

    always #4 clock = ~clock;

    rgmii_tx_multispeed #(
        .DIV_100    (5),
        .DIV_10     (50),
        .FRAME_CNT_W(4)
    ) dut (
        .gmii_tx_clk_i  (clock),
        .rst_i          (reset),
        .speed_sel_i    (speedSel),
        .gmii_tx_en_i   (txEn),
        .gmii_tx_er_i   (txEr),
        .gmii_txd_i     (txData),
        .gmii_tx_ready_o(ready),
        .txc_rise_o     (txcRise),
        .txc_fall_o     (txcFall),
        .ctl_rise_o     (ctlRise),
        .ctl_fall_o     (ctlFall),
        .txd_rise_o     (txdRise),
        .txd_fall_o     (txdFall),
        .busy_o         (busy),
        .frame_cnt_o    (frameCnt)
    );

    typedef struct {
        logic [1:0] speed;
        logic       en;
        logic       er;
        logic [7:0] data;
        logic [3:0] expRise;
        logic [3:0] expFall;
        logic       expCtlRise;
        logic       expCtlFall;
        logic       expTxcRise;
        logic       expTxcFall;
        logic       expReady;
        logic       expBusy;
        logic [3:0] expFrames;
    } vec_t;

    vec_t vecs[14];

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] spd, input logic en, input logic er,
                                 input logic [7:0] data);
        speedSel = spd;
        txEn     = en;
        txEr     = er;
        txData   = data;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Count cycles until ready is observed, bounded by budget
    task automatic waitReady(input int budget, output int n);
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (ready !== 1'b1) begin
            asserts++;
            failures++;
            $display("[TB] FAIL ready_timeout: got no ready, expected ready within %0d cycles", budget);
        end
    endtask

    initial begin
        int         n;
        int         riseCount, fallCount, firstRise;
        logic [4:0] risePat, fallPat;

        //              spd   en  er  data   rise  fall cr cf tr tf rdy busy frames
        vecs[0]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[1]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[2]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[3]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[4]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[5]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[6]  = '{2'b10, 1, 0, 8'h55, 4'h5, 4'h5, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[7]  = '{2'b10, 1, 0, 8'hD5, 4'h5, 4'hD, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[8]  = '{2'b10, 1, 0, 8'hA3, 4'h3, 4'hA, 1, 1, 1, 0, 1, 1, 4'd1};
        vecs[9]  = '{2'b10, 0, 0, 8'hA3, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 4'd1};
        vecs[10] = '{2'b10, 1, 1, 8'h7E, 4'hE, 4'h7, 1, 0, 1, 0, 1, 1, 4'd2};
        vecs[11] = '{2'b01, 1, 0, 8'hB4, 4'h4, 4'hB, 1, 1, 1, 0, 1, 1, 4'd2};
        vecs[12] = '{2'b01, 0, 1, 8'hFF, 4'h0, 4'h0, 0, 1, 1, 0, 1, 0, 4'd2};
        vecs[13] = '{2'b01, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'd2};

        risePat = 5'b11000;
        fallPat = 5'b11100;

        reset = 1'b1;
        applyStimulus(2'b10, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_txc_rise", txcRise, 0);
        checkOutput("reset_txd", {txdRise, txdFall}, 0);
        checkOutput("reset_ctl", {ctlRise, ctlFall}, 0);
        checkOutput("reset_frames", frameCnt, 0);

        reset = 1'b0;
        tick();
        checkOutput("g_first_ready", ready, 1);

        // 1000 passthrough, error encoding, and a speed change that waits for a clean idle slot
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].speed, vecs[i].en, vecs[i].er, vecs[i].data);
            tick();
            checkOutput($sformatf("v%0d_txd_rise", i), txdRise, vecs[i].expRise);
            checkOutput($sformatf("v%0d_txd_fall", i), txdFall, vecs[i].expFall);
            checkOutput($sformatf("v%0d_ctl", i), {ctlRise, ctlFall},
                        {vecs[i].expCtlRise, vecs[i].expCtlFall});
            checkOutput($sformatf("v%0d_txc", i), {txcRise, txcFall},
                        {vecs[i].expTxcRise, vecs[i].expTxcFall});
            checkOutput($sformatf("v%0d_ready", i), ready, vecs[i].expReady);
            checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("v%0d_frames", i), frameCnt, vecs[i].expFrames);
        end

        // 100 mode now runs from cyc=0/LO; first slot lands at HI, cyc=4
        waitReady(40, n);
        checkOutput("m100_first_slot", n, 9);
        applyStimulus(2'b01, 1'b1, 1'b0, 8'h3C);
        tick();
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h00);
        checkOutput("m100_frames", frameCnt, 3);
        checkOutput("m100_ctl", {ctlRise, ctlFall}, 2'b11);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("m100_c%0d_txd_rise", i), txdRise, (i < 5) ? 4'hC : 4'h3);
            checkOutput($sformatf("m100_c%0d_txd_fall", i), txdFall, (i < 5) ? 4'hC : 4'h3);
            checkOutput($sformatf("m100_c%0d_txc_rise", i), txcRise, risePat[i % 5]);
            checkOutput($sformatf("m100_c%0d_txc_fall", i), txcFall, fallPat[i % 5]);
            checkOutput($sformatf("m100_c%0d_ready", i), ready, (i == 9) ? 1 : 0);
            tick();
        end
        checkOutput("m100_idle_busy", busy, 0);
        checkOutput("m100_idle_txd", {txdRise, txdFall}, 0);
        waitReady(40, n);
        checkOutput("m100_ready_period", n + 1, 10);

        // Reset in the middle of a 100 mode frame
        applyStimulus(2'b01, 1'b1, 1'b0, 8'hA5);
        tick();
        checkOutput("rst_pre_frames", frameCnt, 4);
        applyStimulus(2'b01, 1'b1, 1'b0, 8'hA6);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_txd", {txdRise, txdFall}, 0);
        checkOutput("rst_mid_ctl", {ctlRise, ctlFall}, 0);
        checkOutput("rst_mid_txc", {txcRise, txcFall}, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_frames", frameCnt, 0);
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        waitReady(40, n);
        checkOutput("m100_release_ready", n, 10);

        // 10 mode: slot period and TXC half-cycle placement
        reset = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();
        reset = 1'b0;
        waitReady(300, n);
        checkOutput("m10_release_ready", n, 100);
        tick();
        riseCount = 0;
        fallCount = 0;
        firstRise = -1;
        for (int i = 0; i < 50; i++) begin
            if (txcRise === 1'b1) begin
                riseCount++;
                if (firstRise < 0) firstRise = i;
            end
            if (txcFall === 1'b1) fallCount++;
            tick();
        end
        checkOutput("m10_txc_rise_count", riseCount, 25);
        checkOutput("m10_txc_fall_count", fallCount, 25);
        checkOutput("m10_txc_first_high", firstRise, 25);
        waitReady(300, n);
        checkOutput("m10_ready_period", n + 51, 100);

        // Frame counter wraps at 4 bits
        reset = 1'b1;
        applyStimulus(2'b10, 1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        for (int f = 0; f < 17; f++) begin
            applyStimulus(2'b10, 1'b1, 1'b0, 8'h55);
            tick();
            applyStimulus(2'b10, 1'b0, 1'b0, 8'h00);
            tick();
            if (f == 15) checkOutput("wrap_16_frames", frameCnt, 0);
        end
        checkOutput("wrap_17_frames", frameCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_multispeed.md
# rgmii_tx_multispeed

Multi-speed RGMII transmit engine: the tri-speed successor to the 1000-only GMII-to-RGMII TX path. It accepts GMII bytes from the MAC through a ready strobe, serialises them into RGMII nibbles at 1000, 100 or 10 Mbps, and generates TXC. All logic runs in the single 125 MHz GMII TX domain. Outputs are rise/fall bit pairs intended to drive external ODDR primitives for TXC, TX_CTL and TXD[3:0].

## Interface
- DIV_100, default 5: clock cycles per nibble at 100 Mbps (40 ns at 125 MHz).
- DIV_10, default 50: clock cycles per nibble at 10 Mbps.
- FRAME_CNT_W, default 16: width of the frame counter.
- gmii_tx_clk  in  1  125 MHz clock.
- rst  in  1  reset, synchronous, active-high.
- speed_sel  in  2  link speed: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 = 1000.
- gmii_tx_en  in  1  byte valid / in-frame.
- gmii_tx_er  in  1  transmit error.
- gmii_txd  in  8  transmit byte.
- gmii_tx_ready  out  1  byte-accept strobe; the en/er/txd inputs are sampled when it is high.
- txc_rise, txc_fall  out  1 each  TXC levels for the first and second half-cycle.
- ctl_rise, ctl_fall  out  1 each  TX_CTL levels for the first and second half-cycle.
- txd_rise, txd_fall  out  4 each  TXD levels for the first and second half-cycle.
- busy  out  1  high while inside a frame.
- frame_cnt  out  FRAME_CNT_W  count of frame starts; wraps.

## Operation
- **Mode register.** Loaded from speed_sel during reset. Afterwards it is reloaded only in a cycle where ready=1 and the accepted byte has en=0 and er=0.
  - A change to speed_sel during a frame is ignored until the first such idle slot.
  - On a mode change, the nibble counter cyc and the phase reset to 0/LO on the next cycle.
- **Accept rule.** Every ready=1 cycle takes one slot, whether en is high or low. If en=0, an idle byte is sent: data 0, ctl from er.
- **TX_CTL encoding, all modes.** ctl_rise = en, ctl_fall = en ^ er, both taken from the accepted byte.
- **1000 mode.**
  - ready=1 every cycle.
  - Registered outputs: txd_rise = txd[3:0], txd_fall = txd[7:4], txc_rise=1, txc_fall=0.
- **10/100 modes.** N = DIV_100 or DIV_10.
  - States: phase LO, then phase HI, each lasting N cycles; cyc counts 0..N-1.
  - ready=1 only when phase=HI and cyc=N-1, i.e. one strobe every 2N cycles. The slots are continuous whether the link is idle or in a frame.
  - LO phase outputs the low nibble of the byte register and HI phase outputs the high nibble. In both phases txd_rise = txd_fall = the nibble.
  - TXC is free-running. Half-cycle index h = 2·cyc (rise bit) or 2·cyc+1 (fall bit); TXC = 1 when h ≥ N. For N=5 the per-cycle (rise,fall) pattern is (0,0),(0,0),(0,1),(1,1),(1,1).
  - TXC therefore rises at the middle of the nibble, centred on the data.
- **busy.** Set to the en value of each accepted byte.
- **frame_cnt.** Increments by 1 when an accepted byte has en=1 and busy=0, i.e. at the start of a frame. It wraps from 2^W−1 to 0.
- **Reset.**
  - During reset: all outputs 0, ready=0, byte register 0, cyc=0, phase LO.
  - Reset asserted mid-frame truncates the frame immediately. Outputs go to idle in the cycle after rst is sampled high.
  - frame_cnt clears to 0.

## Timing
- **1000 mode.** A byte accepted at cycle t appears on the outputs at t+1. Latency is 1 cycle and throughput is 1 byte per cycle.
- **10/100 modes.**
  - For a byte accepted at cycle t, the low nibble is output during t+1..t+N and the high nibble during t+N+1..t+2N.
  - Throughput is one byte per 2N cycles.
- **Ready after reset release.** In 1000 mode the first ready is in the cycle after rst falls. In 10/100 the first ready is 2N cycles after rst falls.
- **Mode switch.** The cycle after an idle-slot mode change starts cyc=0/LO in the new mode with idle outputs.
- **Input hold.** The MAC must hold en, er and txd stable until ready=1. No input is captured in cycles where ready=0.

## Test plan
- **1000 passthrough.** speed_sel=10; bytes 0x55×7, 0xD5, 0xA3 with en=1, then en=0.
  - txd_rise/txd_fall = 5/5 … 5/D, 3/A, each 1 cycle after acceptance.
  - ctl = 1/1; frame_cnt = 1; busy falls after the last byte.
- **100 serialisation.** speed_sel=01; byte 0x3C, en=1.
  - Outputs are nibble C for 5 cycles, then 3 for 5 cycles.
  - TXC pattern per nibble is (0,0),(0,0),(0,1),(1,1),(1,1).
  - Ready pulses every 10 cycles.
- **10 mode.** speed_sel=00; ready period is 100 cycles; TXC is high from half-cycle 50 through 99 of each nibble.
- **Error encoding.**
  - en=1, er=1 gives ctl_rise=1, ctl_fall=0.
  - en=0, er=1 gives ctl_rise=0, ctl_fall=1, and the mode is not reloaded in that slot.
- **Deferred speed change.** Switch speed_sel from 10 to 01 mid-frame.
  - The 1000 format is held until the first en=0/er=0 slot.
  - The next cycle starts 100 mode with cyc=0.
- **Reset and counter wrap.**
  - rst asserted mid-frame in 100 mode: outputs are idle on the following cycle and frame_cnt=0.
  - With FRAME_CNT_W=4, 17 frames give frame_cnt=1.
